// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit engine.
// Frame length depends on the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Clocks per bit; integer truncation is intended.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the last count.
// clear holds the counter at 0 so the first bit of a frame is a full period.
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter that pops bytes from a show-ahead FIFO and serializes them.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  output logic       tx,
  output logic       tx_busy
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [2:0]             idx_q, idx_d;
  logic                   tx_q, tx_d;
  logic                   tick;
  logic                   clear;

  // Counter is held at zero while idle so START gets exactly DIV clocks.
  assign clear = (state_q == IDLE);

  baud_tick_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // tx_d carries the level of the state being entered, so the registered
  // line changes on the same edge as the state.
  always_comb begin
    // NOTE: every output gets a default first; otherwise paths that skip an
    // assignment would infer latches.
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    fifo_rd = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          data_d  = fifo_rdata;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
`else
        state_d = IDLE;
        tx_d    = 1'b1;
`endif
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a behavioural FIFO feeds the DUT and a
// line monitor rebuilds each frame from tx and compares it with a frame model.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int NS = NBITS * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] junk = 8'h00;

  uart_tx_engine #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected line level for bit k of the frame carrying byte b.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return ((b >> (k - 1)) % 2) == 1;
    if (NBITS == 11 && k == 9) return ($countones(b) % 2) == 1;
    return 1'b1;
  endfunction

  task automatic update_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? junk : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    update_fifo();
  endtask

  // Behavioural show-ahead FIFO: pop happens on the edge where fifo_rd is high.
  initial begin
    logic do_pop;
    forever begin
      @(posedge clk);
      do_pop = fifo_rd;
      #1;
      if (do_pop) begin
        pop_cnt++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        junk = 8'($urandom);
        update_fifo();
      end
    end
  end

  // Line monitor: captures NBITS*DIV samples from each falling start edge.
  logic [NS-1:0] samp;
  bit  capturing = 1'b0;
  bit  prev_b2b = 1'b0;
  int  cap_n = 0;
  int  idle_cnt = 0;
  int  busy_low = 0;

  task automatic finish_frame();
    logic [7:0]       b;
    logic [NBITS-1:0] got_bits, exp_bits;
    int               bad;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    b = exp_q.pop_front();
    bad = 0;
    for (int k = 0; k < NBITS; k++) begin
      exp_bits[k] = model_bit(b, k);
      got_bits[k] = samp[k*DIV + DIV/2];
      for (int c = 0; c < DIV; c++)
        if (samp[k*DIV + c] !== exp_bits[k]) bad++;
    end
    check("frame_bits", 32'(got_bits), 32'(exp_bits));
    check("bit_timing", bad, 0);
    check("busy_in_frame", busy_low, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      capturing = 1'b0;
      prev_b2b  = 1'b0;
      idle_cnt  = 0;
    end else begin
      if (fifo_rd) begin
        check("rd_only_idle", 32'(tx_busy), 0);
        check("rd_nonempty", 32'(fifo_empty), 0);
      end
      if (!capturing) begin
        if (tx == 1'b0) begin
          if (prev_b2b) check("b2b_gap", idle_cnt, 1);
          capturing = 1'b1;
          cap_n     = 0;
          busy_low  = 0;
        end else begin
          idle_cnt++;
        end
      end
      if (capturing) begin
        samp[cap_n] = tx;
        if (!tx_busy) busy_low++;
        cap_n++;
        if (cap_n == NS) begin
          finish_frame();
          capturing = 1'b0;
          idle_cnt  = 0;
          prev_b2b  = !fifo_empty;
        end
      end
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (fifo_empty && !tx_busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (fifo_rd) ok = 1'b1;
    end
    if (!ok) check("pop_timeout", 1, 0);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int  p0, busy_n, bad_rd, bad_tx, bad_busy;
    bit  ok;

    // Reset and quiet line
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_rd", 32'(fifo_rd), 0);
    drive_edge();
    reset = 1'b0;
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
      if (tx_busy) bad_busy++;
    end
    check("idle_rd_cycles", bad_rd, 0);
    check("idle_tx_low_cycles", bad_tx, 0);
    check("idle_busy_cycles", bad_busy, 0);

    // Single 8'hA5 frame with busy-length measurement
    drive_edge();
    p0 = pop_cnt;
    push(8'hA5);
    busy_n = 0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    if (!ok) check("busy_rise_timeout", 1, 0);
    for (int i = 0; i < 500 && tx_busy; i++) begin
      busy_n++;
      @(negedge clk);
    end
    check("busy_len", busy_n, NS);
    wait_idle();
    check("a5_pops", pop_cnt - p0, 1);

    // Back-to-back 00, FF, then 01 parity case
    drive_edge();
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    wait_idle();
    check("b2b_pops", pop_cnt - p0, 2);
    drive_edge();
    push(8'h01);
    wait_idle();

    // Head byte changes mid-frame: frame in flight must stay 8'h5A
    drive_edge();
    push(8'h5A);
    wait_pop(ok);
    @(posedge clk);
    repeat (43) @(posedge clk);
    #2;
    push(8'h3C);
    wait_idle();

    // Reset at clock 45 of an 8'h81 frame; popped byte is dropped
    drive_edge();
    push(8'h81);
    push(8'h42);
    wait_pop(ok);
    @(posedge clk);
    repeat (45) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_rd", 32'(fifo_rd), 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (3) @(posedge clk);
    #2;
    check("rst_held_rd", 32'(fifo_rd), 0);
    reset = 1'b0;
    wait_idle();

    // Random batches, some back-to-back
    for (int batch = 0; batch < 4; batch++) begin
      int n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        drive_edge();
        push(8'($urandom));
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("fifo_drained", fifo_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
